// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Brief    : Oversampled UART receiver. Two-flop input synchronizer,
//             start-bit qualification at mid-bit, LSB-first data capture,
//             stop-bit check with frame-error pulse, break handling and a
//             valid/ready output with sticky overrun flag.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int OVERSAMPLE = 8,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 rx_serial,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int c_TICK_W = $clog2(OVERSAMPLE);
    localparam int c_BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_MID  = c_TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_ONE   = c_BIT_W'(1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_STOP  = 3'd3;
    localparam logic [2:0] c_ST_BREAK = 3'd4;

    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic                 r_sync_meta;
    logic                 r_sync;
    logic [c_TICK_W-1:0]  r_tick_cnt;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_error;
    logic                 r_overrun;
    logic                 w_tick_last;
    logic                 w_stop_good;
    logic                 w_stop_bad;
    logic                 w_handshake;
    logic                 w_busy;

    // Two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync_meta <= 1'b1;
            r_sync      <= 1'b1;
        end else begin
            r_sync_meta <= rx_serial;
            r_sync      <= r_sync_meta;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; the state only advances on a baud tick
    always_comb begin
        w_state_next = r_state;
        if (baud_tick) begin
            case (r_state)
                c_ST_IDLE:  if (!r_sync) w_state_next = c_ST_START;
                c_ST_START: if (r_tick_cnt == c_TICK_MID)
                                w_state_next = r_sync ? c_ST_IDLE : c_ST_DATA;
                c_ST_DATA:  if ((r_tick_cnt == c_TICK_LAST) && (r_bit_cnt == c_BIT_LAST))
                                w_state_next = c_ST_STOP;
                c_ST_STOP:  if (r_tick_cnt == c_TICK_LAST)
                                w_state_next = r_sync ? c_ST_IDLE : c_ST_BREAK;
                c_ST_BREAK: if (r_sync) w_state_next = c_ST_IDLE;
                default:    w_state_next = c_ST_IDLE;
            endcase
        end
    end

    // Output/strobe decode from the current state
    always_comb begin
        w_tick_last = baud_tick && (r_tick_cnt == c_TICK_LAST);
        w_stop_good = (r_state == c_ST_STOP) && w_tick_last && r_sync;
        w_stop_bad  = (r_state == c_ST_STOP) && w_tick_last && !r_sync;
        w_busy      = (r_state != c_ST_IDLE);
    end

    // Next shift-register value: new bit enters at the MSB so the first bit ends at the LSB
    always_comb begin
        w_shift_next                = r_shift >> 1;
        w_shift_next[DATA_BITS-1]   = r_sync;
    end

    // Bit timing counters and data shift register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else if (baud_tick) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!r_sync) r_tick_cnt <= '0;
                end
                c_ST_START: begin
                    if (r_tick_cnt == c_TICK_MID) begin
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + c_TICK_ONE;
                    end
                end
                c_ST_DATA: begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        r_shift    <= w_shift_next;
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= r_bit_cnt + c_BIT_ONE;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + c_TICK_ONE;
                    end
                end
                c_ST_STOP: begin
                    if (r_tick_cnt == c_TICK_LAST) r_tick_cnt <= '0;
                    else                           r_tick_cnt <= r_tick_cnt + c_TICK_ONE;
                end
                default: begin
                    r_tick_cnt <= r_tick_cnt;
                end
            endcase
        end
    end

    assign w_handshake = r_rx_valid && rx_ready;

    // Consumer-facing registers: a completed frame takes priority over a handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_frame_error <= w_stop_bad;
            if (w_stop_good) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
                if (r_rx_valid && !rx_ready) r_overrun <= 1'b1;
            end else if (w_handshake) begin
                r_rx_valid <= 1'b0;
                r_overrun  <= 1'b0;
            end
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_error = r_frame_error;
    assign overrun     = r_overrun;
    assign busy        = w_busy;

endmodule
`default_nettype wire
